// File: rtl/calc2_req_arbiter.sv
// Four-port request collector feeding a single registered ALU issue interface.
// Each port captures a two-beat command, waits for round-robin issue, and receives its response.
module calc2_req_arbiter (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req1_cmd_in,
    input  logic [31:0] req1_data_in,
    input  logic [1:0]  req1_tag_in,
    input  logic [3:0]  req2_cmd_in,
    input  logic [31:0] req2_data_in,
    input  logic [1:0]  req2_tag_in,
    input  logic [3:0]  req3_cmd_in,
    input  logic [31:0] req3_data_in,
    input  logic [1:0]  req3_tag_in,
    input  logic [3:0]  req4_cmd_in,
    input  logic [31:0] req4_data_in,
    input  logic [1:0]  req4_tag_in,
    output logic [1:0]  out_resp1,
    output logic [31:0] out_data1,
    output logic [1:0]  out_tag1,
    output logic [1:0]  out_resp2,
    output logic [31:0] out_data2,
    output logic [1:0]  out_tag2,
    output logic [1:0]  out_resp3,
    output logic [31:0] out_data3,
    output logic [1:0]  out_tag3,
    output logic [1:0]  out_resp4,
    output logic [31:0] out_data4,
    output logic [1:0]  out_tag4,
    output logic        alu_valid,
    input  logic        alu_ready,
    output logic [3:0]  alu_cmd,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [1:0]  alu_port,
    output logic [1:0]  alu_tag,
    input  logic        alu_rsp_valid,
    input  logic [1:0]  alu_rsp_code,
    input  logic [31:0] alu_rsp_data,
    input  logic [1:0]  alu_rsp_port,
    input  logic [1:0]  alu_rsp_tag,
    output logic [7:0]  drop_cnt
);

    typedef enum logic [1:0] {StIdle, StOp2, StPend, StIssued} slot_state_e;

    logic [3:0]  w_cmd_in  [4];
    logic [31:0] w_data_in [4];
    logic [1:0]  w_tag_in  [4];

    slot_state_e r_state [4];
    slot_state_e w_state_d [4];
    logic [3:0]  r_cmd [4];
    logic [31:0] r_op1 [4];
    logic [31:0] r_op2 [4];
    logic [1:0]  r_tag [4];

    logic [1:0]  r_resp  [4];
    logic [1:0]  w_resp_d [4];
    logic [31:0] r_rdata [4];
    logic [31:0] w_rdata_d [4];
    logic [1:0]  r_rtag  [4];
    logic [1:0]  w_rtag_d [4];

    logic        r_alu_valid;
    logic [3:0]  r_alu_cmd;
    logic [31:0] r_alu_op1;
    logic [31:0] r_alu_op2;
    logic [1:0]  r_alu_port;
    logic [1:0]  r_alu_tag;
    logic [1:0]  r_rr_ptr;

    logic [7:0]  r_drop_cnt;
    logic [7:0]  w_drop_cnt_d;
    logic [3:0]  w_drop;
    logic [2:0]  w_drop_sum;
    logic [8:0]  w_drop_total;

    logic        w_load;
    logic        w_found;
    logic        w_grant;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;

    assign w_cmd_in[0]  = req1_cmd_in;
    assign w_cmd_in[1]  = req2_cmd_in;
    assign w_cmd_in[2]  = req3_cmd_in;
    assign w_cmd_in[3]  = req4_cmd_in;
    assign w_data_in[0] = req1_data_in;
    assign w_data_in[1] = req2_data_in;
    assign w_data_in[2] = req3_data_in;
    assign w_data_in[3] = req4_data_in;
    assign w_tag_in[0]  = req1_tag_in;
    assign w_tag_in[1]  = req2_tag_in;
    assign w_tag_in[2]  = req3_tag_in;
    assign w_tag_in[3]  = req4_tag_in;

    function automatic logic cmd_is_valid(input logic [3:0] cmd);
        return (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
    endfunction

    // The issue register may only reload once its current contents are taken (or it is empty).
    assign w_load  = !r_alu_valid || alu_ready;
    assign w_grant = w_load && w_found;

    // Round-robin search over PEND slots, starting at r_rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_rr_ptr + 2'(i);
            if (!w_found && r_state[w_idx] == StPend) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            w_state_d[p] = r_state[p];
            w_resp_d[p]  = 2'd0;
            w_rdata_d[p] = 32'd0;
            w_rtag_d[p]  = 2'd0;
            w_drop[p]    = 1'b0;
            unique case (r_state[p])
                StIdle: begin
                    if (w_cmd_in[p] != 4'd0) w_state_d[p] = StOp2;
                end
                StOp2: begin
                    if (cmd_is_valid(r_cmd[p])) begin
                        w_state_d[p] = StPend;
                    end else begin
                        w_state_d[p] = StIdle;
                        w_resp_d[p]  = 2'd2;
                        w_rtag_d[p]  = r_tag[p];
                    end
                end
                StPend: begin
                    w_drop[p] = (w_cmd_in[p] != 4'd0);
                    if (w_grant && w_win == 2'(p)) w_state_d[p] = StIssued;
                end
                StIssued: begin
                    w_drop[p] = (w_cmd_in[p] != 4'd0);
                    if (alu_rsp_valid && alu_rsp_port == 2'(p)) begin
                        w_state_d[p] = StIdle;
                        w_resp_d[p]  = alu_rsp_code;
                        w_rdata_d[p] = alu_rsp_data;
                        w_rtag_d[p]  = alu_rsp_tag;
                    end
                end
                default: w_state_d[p] = StIdle;
            endcase
        end
    end

    always_comb begin
        w_drop_sum   = 3'(w_drop[0]) + 3'(w_drop[1]) + 3'(w_drop[2]) + 3'(w_drop[3]);
        w_drop_total = {1'b0, r_drop_cnt} + 9'(w_drop_sum);
        w_drop_cnt_d = (w_drop_total > 9'd255) ? 8'hff : w_drop_total[7:0];
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 4; p++) begin
                r_state[p] <= StIdle;
                r_cmd[p]   <= 4'd0;
                r_op1[p]   <= 32'd0;
                r_op2[p]   <= 32'd0;
                r_tag[p]   <= 2'd0;
                r_resp[p]  <= 2'd0;
                r_rdata[p] <= 32'd0;
                r_rtag[p]  <= 2'd0;
            end
            r_drop_cnt <= 8'd0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                r_state[p] <= w_state_d[p];
                r_resp[p]  <= w_resp_d[p];
                r_rdata[p] <= w_rdata_d[p];
                r_rtag[p]  <= w_rtag_d[p];
                if (r_state[p] == StIdle && w_cmd_in[p] != 4'd0) begin
                    r_cmd[p] <= w_cmd_in[p];
                    r_op1[p] <= w_data_in[p];
                    r_tag[p] <= w_tag_in[p];
                end
                if (r_state[p] == StOp2) r_op2[p] <= w_data_in[p];
            end
            r_drop_cnt <= w_drop_cnt_d;
        end
    end

    // An empty load edge clears valid only; payload and pointer are left as they were.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            r_alu_valid <= 1'b0;
            r_alu_cmd   <= 4'd0;
            r_alu_op1   <= 32'd0;
            r_alu_op2   <= 32'd0;
            r_alu_port  <= 2'd0;
            r_alu_tag   <= 2'd0;
            r_rr_ptr    <= 2'd0;
        end else if (w_load) begin
            r_alu_valid <= w_found;
            if (w_found) begin
                r_alu_cmd  <= r_cmd[w_win];
                r_alu_op1  <= r_op1[w_win];
                r_alu_op2  <= r_op2[w_win];
                r_alu_port <= w_win;
                r_alu_tag  <= r_tag[w_win];
                r_rr_ptr   <= w_win + 2'd1;
            end
        end
    end

    assign alu_valid = r_alu_valid;
    assign alu_cmd   = r_alu_cmd;
    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;
    assign alu_port  = r_alu_port;
    assign alu_tag   = r_alu_tag;
    assign drop_cnt  = r_drop_cnt;

    assign out_resp1 = r_resp[0];
    assign out_data1 = r_rdata[0];
    assign out_tag1  = r_rtag[0];
    assign out_resp2 = r_resp[1];
    assign out_data2 = r_rdata[1];
    assign out_tag2  = r_rtag[1];
    assign out_resp3 = r_resp[2];
    assign out_data3 = r_rdata[2];
    assign out_tag3  = r_rtag[2];
    assign out_resp4 = r_resp[3];
    assign out_data4 = r_rdata[3];
    assign out_tag4  = r_rtag[3];

endmodule

// File: tb/tb_calc2_req_arbiter.sv
// Directed bench for calc2_req_arbiter: two-beat capture, issue timing, round-robin, backpressure,
// drop counting and mid-flight reset.
module tb_calc2_req_arbiter;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd_in  [4];
    logic [31:0] data_in [4];
    logic [1:0]  tag_in  [4];
    logic [1:0]  o_resp  [4];
    logic [31:0] o_data  [4];
    logic [1:0]  o_tag   [4];
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_cmd;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [1:0]  alu_port;
    logic [1:0]  alu_tag;
    logic        alu_rsp_valid;
    logic [1:0]  alu_rsp_code;
    logic [31:0] alu_rsp_data;
    logic [1:0]  alu_rsp_port;
    logic [1:0]  alu_rsp_tag;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    calc2_req_arbiter dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req1_cmd_in   (cmd_in[0]),
        .req1_data_in  (data_in[0]),
        .req1_tag_in   (tag_in[0]),
        .req2_cmd_in   (cmd_in[1]),
        .req2_data_in  (data_in[1]),
        .req2_tag_in   (tag_in[1]),
        .req3_cmd_in   (cmd_in[2]),
        .req3_data_in  (data_in[2]),
        .req3_tag_in   (tag_in[2]),
        .req4_cmd_in   (cmd_in[3]),
        .req4_data_in  (data_in[3]),
        .req4_tag_in   (tag_in[3]),
        .out_resp1     (o_resp[0]),
        .out_data1     (o_data[0]),
        .out_tag1      (o_tag[0]),
        .out_resp2     (o_resp[1]),
        .out_data2     (o_data[1]),
        .out_tag2      (o_tag[1]),
        .out_resp3     (o_resp[2]),
        .out_data3     (o_data[2]),
        .out_tag3      (o_tag[2]),
        .out_resp4     (o_resp[3]),
        .out_data4     (o_data[3]),
        .out_tag4      (o_tag[3]),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_cmd       (alu_cmd),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_port      (alu_port),
        .alu_tag       (alu_tag),
        .alu_rsp_valid (alu_rsp_valid),
        .alu_rsp_code  (alu_rsp_code),
        .alu_rsp_data  (alu_rsp_data),
        .alu_rsp_port  (alu_rsp_port),
        .alu_rsp_tag   (alu_rsp_tag),
        .drop_cnt      (drop_cnt)
    );

    always #5 c_clk = ~c_clk;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge c_clk);
        #1;
    endtask

    task automatic drive_req(input int p, input logic [3:0] cmd, input logic [31:0] d,
                             input logic [1:0] t);
        cmd_in[p]  = cmd;
        data_in[p] = d;
        tag_in[p]  = t;
    endtask

    // Two edges: command beat then operand-2 beat; returns just after the op2 edge.
    task automatic send_req(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                            input logic [31:0] op2, input logic [1:0] t);
        drive_req(p, cmd, op1, t);
        tick();
        drive_req(p, 4'd0, op2, 2'd0);
        tick();
        data_in[p] = 32'd0;
    endtask

    task automatic send_rsp(input logic [1:0] port, input logic [1:0] code,
                            input logic [31:0] d, input logic [1:0] t);
        alu_rsp_valid = 1'b1;
        alu_rsp_port  = port;
        alu_rsp_code  = code;
        alu_rsp_data  = d;
        alu_rsp_tag   = t;
        tick();
        alu_rsp_valid = 1'b0;
        alu_rsp_code  = 2'd0;
        alu_rsp_data  = 32'd0;
        alu_rsp_port  = 2'd0;
        alu_rsp_tag   = 2'd0;
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (alu_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_alu_valid got %0b want 0", alu_valid);
        end
        n_checks++;
        if ({alu_cmd, alu_op1, alu_op2, alu_port, alu_tag} !== 72'd0) begin
            n_errors++; $display("FAIL reset_alu_bus got %h/%h/%h/%0d/%0d want 0", alu_cmd,
                                 alu_op1, alu_op2, alu_port, alu_tag);
        end
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt);
        end
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if ({o_resp[p], o_data[p], o_tag[p]} !== 36'd0) begin
                n_errors++; $display("FAIL reset_out%0d got %0d/%h/%0d want 0", p + 1, o_resp[p],
                                     o_data[p], o_tag[p]);
            end
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        alu_ready = 1'b1;
        send_req(0, 4'd1, 32'h30, 32'h20, 2'd2);
        n_checks++;
        if (alu_valid !== 1'b0) begin
            n_errors++; $display("FAIL add_early_valid got %0b want 0", alu_valid);
        end
        tick();
        n_checks++;
        if ({alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag} !==
            {1'b1, 4'd1, 32'h30, 32'h20, 2'd0, 2'd2}) begin
            n_errors++; $display("FAIL add_issue got v%0b c%0d %h %h p%0d t%0d want v1 c1 30 20 p0 t2",
                                 alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag);
        end
        tick();
        n_checks++;
        if (alu_valid !== 1'b0) begin
            n_errors++; $display("FAIL add_no_reissue got %0b want 0", alu_valid);
        end
        send_rsp(2'd0, 2'd1, 32'h50, 2'd2);
        n_checks++;
        if ({o_resp[0], o_data[0], o_tag[0]} !== {2'd1, 32'h50, 2'd2}) begin
            n_errors++; $display("FAIL add_resp got %0d/%h/%0d want 1/50/2", o_resp[0], o_data[0],
                                 o_tag[0]);
        end
        tick();
        n_checks++;
        if ({o_resp[0], o_data[0], o_tag[0]} !== 36'd0) begin
            n_errors++; $display("FAIL add_resp_one_cycle got %0d/%h/%0d want 0", o_resp[0],
                                 o_data[0], o_tag[0]);
        end
    endtask

    task automatic test_invalid_cmd();
        drive_req(2, 4'd4, 32'hDEAD, 2'd1);
        tick();
        drive_req(2, 4'd0, 32'hBEEF, 2'd0);
        tick();
        data_in[2] = 32'd0;
        n_checks++;
        if ({o_resp[2], o_data[2], o_tag[2]} !== {2'd2, 32'd0, 2'd1}) begin
            n_errors++; $display("FAIL inv_resp got %0d/%h/%0d want 2/0/1", o_resp[2], o_data[2],
                                 o_tag[2]);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (alu_valid !== 1'b0 || o_resp[2] !== 2'd0) begin
                n_errors++; $display("FAIL inv_quiet got valid %0b resp %0d want 0/0", alu_valid,
                                     o_resp[2]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_a [2];
        pulse_reset();
        alu_ready = 1'b1;
        for (int p = 0; p < 4; p++) drive_req(p, 4'd2, 32'(p + 16), 2'(p));
        tick();
        for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 32'(p), 2'd0);
        tick();
        for (int p = 0; p < 4; p++) data_in[p] = 32'd0;
        for (int p = 0; p < 4; p++) begin
            tick();
            n_checks++;
            if ({alu_valid, alu_port, alu_op1, alu_tag} !== {1'b1, 2'(p), 32'(p + 16), 2'(p)}) begin
                n_errors++; $display("FAIL rr_all got v%0b p%0d op1 %h t%0d want v1 p%0d op1 %h t%0d",
                                     alu_valid, alu_port, alu_op1, alu_tag, p, p + 16, p);
            end
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            send_rsp(2'(p), 2'd1, 32'(p + 100), 2'(p));
            n_checks++;
            if ({o_resp[p], o_data[p]} !== {2'd1, 32'(p + 100)}) begin
                n_errors++; $display("FAIL rr_rsp%0d got %0d/%h want 1/%h", p + 1, o_resp[p],
                                     o_data[p], p + 100);
            end
        end
        // Pointer back at port 1, then moved to port 3, so the two pair rounds order differently.
        exp_a[0] = 2'd0; exp_a[1] = 2'd3;
        for (int round = 0; round < 2; round++) begin
            if (round == 1) begin
                send_req(1, 4'd6, 32'd1, 32'd1, 2'd0);
                tick();
                n_checks++;
                if (alu_valid !== 1'b1 || alu_port !== 2'd1) begin
                    n_errors++; $display("FAIL rr_solo got v%0b p%0d want v1 p1", alu_valid,
                                         alu_port);
                end
                tick();
                send_rsp(2'd1, 2'd1, 32'd0, 2'd0);
                exp_a[0] = 2'd3; exp_a[1] = 2'd0;
            end
            drive_req(0, 4'd5, 32'd7, 2'd0);
            drive_req(3, 4'd1, 32'd9, 2'd3);
            tick();
            drive_req(0, 4'd0, 32'd1, 2'd0);
            drive_req(3, 4'd0, 32'd1, 2'd0);
            tick();
            data_in[0] = 32'd0;
            data_in[3] = 32'd0;
            for (int k = 0; k < 2; k++) begin
                tick();
                n_checks++;
                if (alu_valid !== 1'b1 || alu_port !== exp_a[k]) begin
                    n_errors++; $display("FAIL rr_pair%0d_%0d got v%0b p%0d want v1 p%0d", round, k,
                                         alu_valid, alu_port, exp_a[k]);
                end
            end
            tick();
            send_rsp(2'd0, 2'd1, 32'd0, 2'd0);
            send_rsp(2'd3, 2'd1, 32'd0, 2'd3);
        end
    endtask

    task automatic test_backpressure();
        alu_ready = 1'b0;
        send_req(1, 4'd2, 32'h100, 32'h10, 2'd3);
        tick();
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag} !==
                {1'b1, 4'd2, 32'h100, 32'h10, 2'd1, 2'd3}) begin
                n_errors++; $display("FAIL bp_hold%0d got v%0b c%0d %h %h p%0d t%0d want v1 c2 100 10 p1 t3",
                                     k, alu_valid, alu_cmd, alu_op1, alu_op2, alu_port, alu_tag);
            end
            tick();
        end
        alu_ready = 1'b1;
        tick();
        n_checks++;
        if (alu_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_no_dup got %0b want 0", alu_valid);
        end
        send_rsp(2'd1, 2'd3, 32'hF0, 2'd3);
        n_checks++;
        if ({o_resp[1], o_data[1], o_tag[1]} !== {2'd3, 32'hF0, 2'd3}) begin
            n_errors++; $display("FAIL bp_resp got %0d/%h/%0d want 3/f0/3", o_resp[1], o_data[1],
                                 o_tag[1]);
        end
    endtask

    task automatic test_drop();
        alu_ready = 1'b1;
        send_req(0, 4'd1, 32'd1, 32'd2, 2'd0);
        tick();
        send_req(1, 4'd5, 32'd3, 32'd1, 2'd1);
        tick();
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++; $display("FAIL drop_start got %0d want 0", drop_cnt);
        end
        cmd_in[0] = 4'd6;
        tick();
        cmd_in[0] = 4'd0;
        n_checks++;
        if (drop_cnt !== 8'd1) begin
            n_errors++; $display("FAIL drop_one got %0d want 1", drop_cnt);
        end
        cmd_in[0] = 4'd1;
        cmd_in[1] = 4'd9;
        tick();
        n_checks++;
        if (drop_cnt !== 8'd3) begin
            n_errors++; $display("FAIL drop_two_ports got %0d want 3", drop_cnt);
        end
        for (int k = 0; k < 100; k++) tick();
        n_checks++;
        if (drop_cnt !== 8'd203) begin
            n_errors++; $display("FAIL drop_mid got %0d want 203", drop_cnt);
        end
        for (int k = 0; k < 50; k++) tick();
        cmd_in[0] = 4'd0;
        cmd_in[1] = 4'd0;
        n_checks++;
        if (drop_cnt !== 8'd255) begin
            n_errors++; $display("FAIL drop_saturate got %0d want 255", drop_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        // Ports 1 and 2 are still ISSUED from the drop scenario; reset lands between edges.
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (drop_cnt !== 8'd0 || alu_cmd !== 4'd0 || alu_port !== 2'd0 || alu_op1 !== 32'd0) begin
            n_errors++; $display("FAIL rst_async got drop %0d cmd %0d port %0d op1 %h want 0",
                                 drop_cnt, alu_cmd, alu_port, alu_op1);
        end
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        send_rsp(2'd1, 2'd1, 32'hAA, 2'd1);
        for (int p = 0; p < 4; p++) begin
            n_checks++;
            if ({o_resp[p], o_data[p], o_tag[p]} !== 36'd0) begin
                n_errors++; $display("FAIL rst_late_rsp out%0d got %0d/%h/%0d want 0", p + 1,
                                     o_resp[p], o_data[p], o_tag[p]);
            end
        end
        n_checks++;
        if (alu_valid !== 1'b0) begin
            n_errors++; $display("FAIL rst_alu_valid got %0b want 0", alu_valid);
        end
    endtask

    initial begin
        reset         = 1'b0;
        alu_ready     = 1'b0;
        alu_rsp_valid = 1'b0;
        alu_rsp_code  = 2'd0;
        alu_rsp_data  = 32'd0;
        alu_rsp_port  = 2'd0;
        alu_rsp_tag   = 2'd0;
        for (int p = 0; p < 4; p++) drive_req(p, 4'd0, 32'd0, 2'd0);
        test_reset();
        test_single_add();
        test_invalid_cmd();
        test_fairness();
        test_backpressure();
        test_drop();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
